// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - request/response and memory-side signal bundle for mem_port_arbiter
// Purpose: groups both requester channels and the memory port of the arbiter.
// Ports (signals):
//   req0_*/req1_* : valid/ready request channel (we, addr, wdata, wstrb) per port
//   rsp0_*/rsp1_* : one-cycle completion pulse and read data per port
//   mem_*         : single-port fixed-latency memory strobe, controls and read data
// Modports: slave = arbiter view, master = requesters plus memory view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic              req0_we;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [3:0]        req0_wstrb;

  logic              req1_valid;
  logic              req1_ready;
  logic              req1_we;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [3:0]        req1_wstrb;

  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_rdata, rsp1_valid, rsp1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin two-port arbiter for a single-port fixed-latency memory
// Purpose: shares one memory between instruction fetch (port 0) and data load/store (port 1),
//   one transaction at a time: IDLE accept -> ISSUE (mem_en) -> WAIT latency -> RESP pulse.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.slave (req0/req1, rsp0/rsp1, mem_*)
// Parameters: ADDR_W address width; DATA_W must be 32; LATENCY 1..7 cycles from mem_en to mem_rdata.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // WAIT lasts LATENCY cycles: counter runs LATENCY-1 down to 0.
  localparam logic [2:0] CNT_LOAD = 3'(LATENCY - 1);

  state_t            state_q;
  state_t            state_d;
  logic              last_q;
  logic              port_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wstrb_q;
  logic [2:0]        cnt_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              grant;
  logic              grant_port;

  // Grant only in IDLE; on contention the port not served last wins.
  always_comb begin
    grant      = 1'b0;
    grant_port = 1'b0;
    if (state_q == IDLE) begin
      if (bus.req0_valid && bus.req1_valid) begin
        grant      = 1'b1;
        grant_port = ~last_q;
      end else if (bus.req0_valid) begin
        grant      = 1'b1;
        grant_port = 1'b0;
      end else if (bus.req1_valid) begin
        grant      = 1'b1;
        grant_port = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 3'd0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= 4'h0;
      cnt_q    <= 3'd0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            port_q  <= grant_port;
            last_q  <= grant_port;
            we_q    <= grant_port ? bus.req1_we    : bus.req0_we;
            addr_q  <= grant_port ? bus.req1_addr  : bus.req0_addr;
            wdata_q <= grant_port ? bus.req1_wdata : bus.req0_wdata;
            wstrb_q <= grant_port ? bus.req1_wstrb : bus.req0_wstrb;
          end
        end
        ISSUE: cnt_q <= CNT_LOAD;
        WAIT: begin
          if (cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
          end else if (port_q) begin
            rdata1_q <= we_q ? '0 : bus.mem_rdata;
          end else begin
            rdata0_q <= we_q ? '0 : bus.mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = grant & ~grant_port;
  assign bus.req1_ready = grant & grant_port;

  // Memory fields come straight from the latch, so they hold outside ISSUE.
  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = (state_q == ISSUE) & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

  assign bus.rsp0_valid = (state_q == RESP) & ~port_q;
  assign bus.rsp1_valid = (state_q == RESP) & port_q;
  assign bus.rsp0_rdata = rdata0_q;
  assign bus.rsp1_rdata = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter at LATENCY 2 and 3
module tb_mem_port_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_a ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_b ();

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  // requester drive, indexed [instance][port]
  logic        dv  [2][2];
  logic        dwe [2][2];
  logic [31:0] da  [2][2];
  logic [31:0] dd  [2][2];
  logic [3:0]  ds  [2][2];

  assign bus_a.req0_valid = dv[0][0];  assign bus_a.req0_we = dwe[0][0];
  assign bus_a.req0_addr  = da[0][0];  assign bus_a.req0_wdata = dd[0][0];
  assign bus_a.req0_wstrb = ds[0][0];
  assign bus_a.req1_valid = dv[0][1];  assign bus_a.req1_we = dwe[0][1];
  assign bus_a.req1_addr  = da[0][1];  assign bus_a.req1_wdata = dd[0][1];
  assign bus_a.req1_wstrb = ds[0][1];
  assign bus_b.req0_valid = dv[1][0];  assign bus_b.req0_we = dwe[1][0];
  assign bus_b.req0_addr  = da[1][0];  assign bus_b.req0_wdata = dd[1][0];
  assign bus_b.req0_wstrb = ds[1][0];
  assign bus_b.req1_valid = dv[1][1];  assign bus_b.req1_we = dwe[1][1];
  assign bus_b.req1_addr  = da[1][1];  assign bus_b.req1_wdata = dd[1][1];
  assign bus_b.req1_wstrb = ds[1][1];

  // memory contents are a fixed function of the address
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return a * 32'h9E3779B1 + 32'h01234567;
  endfunction

  // memory model: data valid exactly LAT cycles after the mem_en cycle, junk otherwise
  logic        rd_act_a = 1'b0;
  logic [2:0]  rd_cnt_a = 3'd0;
  logic [31:0] rd_adr_a = 32'h0;
  logic        rd_act_b = 1'b0;
  logic [2:0]  rd_cnt_b = 3'd0;
  logic [31:0] rd_adr_b = 32'h0;

  always @(posedge clk) begin
    if (bus_a.mem_en && !bus_a.mem_we) begin
      rd_act_a <= 1'b1; rd_cnt_a <= 3'(LAT_A - 1); rd_adr_a <= bus_a.mem_addr;
    end else if (rd_act_a) begin
      if (rd_cnt_a == 3'd0) rd_act_a <= 1'b0; else rd_cnt_a <= rd_cnt_a - 3'd1;
    end
    if (bus_b.mem_en && !bus_b.mem_we) begin
      rd_act_b <= 1'b1; rd_cnt_b <= 3'(LAT_B - 1); rd_adr_b <= bus_b.mem_addr;
    end else if (rd_act_b) begin
      if (rd_cnt_b == 3'd0) rd_act_b <= 1'b0; else rd_cnt_b <= rd_cnt_b - 3'd1;
    end
  end

  assign bus_a.mem_rdata = (rd_act_a && rd_cnt_a == 3'd0) ? memfn(rd_adr_a) : 32'hBAD0BAD0;
  assign bus_b.mem_rdata = (rd_act_b && rd_cnt_b == 3'd0) ? memfn(rd_adr_b) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // reference model: one transaction per LAT+3 cycles, fixed event offsets from acceptance
  int          free_at  [2];
  int          last_g   [2];
  int          en_cyc   [2];
  int          rsp_cyc  [2];
  int          rsp_port [2];
  int          acc_n    [2];
  int          rsp_n    [2];
  int          en_n     [2];
  logic [31:0] rsp_exp  [2];
  logic [31:0] hold0    [2];
  logic [31:0] hold1    [2];
  logic        l_we     [2];
  logic [31:0] l_addr   [2];
  logic [31:0] l_wdata  [2];
  logic [3:0]  l_wstrb  [2];
  int          glog0 [$];
  int          alog1 [$];

  task automatic mon(input int i, input int lat,
                     input logic rdy0, input logic rdy1, input logic en, input logic we,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                     input logic rv0, input logic rv1, input logic [31:0] rd0, input logic [31:0] rd1);
    int    eg;
    string pre;
    pre = (i == 0) ? "a_" : "b_";
    if (!reset) begin
      chk({pre, "rst_ready0"}, rdy0, 0);
      chk({pre, "rst_ready1"}, rdy1, 0);
      chk({pre, "rst_mem_en"}, en, 0);
      chk({pre, "rst_mem_we"}, we, 0);
      chk({pre, "rst_mem_addr"}, addr, 0);
      chk({pre, "rst_mem_wdata"}, wdata, 0);
      chk({pre, "rst_mem_wstrb"}, wstrb, 0);
      chk({pre, "rst_rsp0_valid"}, rv0, 0);
      chk({pre, "rst_rsp1_valid"}, rv1, 0);
      chk({pre, "rst_rsp0_rdata"}, rd0, 0);
      chk({pre, "rst_rsp1_rdata"}, rd1, 0);
      free_at[i] = 0; last_g[i] = 1; en_cyc[i] = -1; rsp_cyc[i] = -1; rsp_port[i] = 0;
      acc_n[i] = 0; rsp_n[i] = 0; rsp_exp[i] = 0; hold0[i] = 0; hold1[i] = 0;
      l_we[i] = 0; l_addr[i] = 0; l_wdata[i] = 0; l_wstrb[i] = 0;
      return;
    end
    chk({pre, "mem_en"}, en, (cyc == en_cyc[i]));
    if (en) en_n[i]++;
    chk({pre, "mem_we"}, we, (cyc == en_cyc[i]) && l_we[i]);
    chk({pre, "mem_addr"}, addr, l_addr[i]);
    chk({pre, "mem_wdata"}, wdata, l_wdata[i]);
    chk({pre, "mem_wstrb"}, wstrb, l_wstrb[i]);
    if (cyc == rsp_cyc[i]) begin
      if (rsp_port[i] == 0) hold0[i] = rsp_exp[i]; else hold1[i] = rsp_exp[i];
    end
    chk({pre, "rsp0_valid"}, rv0, (cyc == rsp_cyc[i]) && rsp_port[i] == 0);
    chk({pre, "rsp1_valid"}, rv1, (cyc == rsp_cyc[i]) && rsp_port[i] == 1);
    if (rv0 || rv1) rsp_n[i]++;
    chk({pre, "rsp0_rdata"}, rd0, hold0[i]);
    chk({pre, "rsp1_rdata"}, rd1, hold1[i]);
    eg = -1;
    if (cyc >= free_at[i]) begin
      if (dv[i][0] && dv[i][1]) eg = (last_g[i] == 1) ? 0 : 1;
      else if (dv[i][0])        eg = 0;
      else if (dv[i][1])        eg = 1;
    end
    chk({pre, "req0_ready"}, rdy0, (eg == 0));
    chk({pre, "req1_ready"}, rdy1, (eg == 1));
    if (eg >= 0) begin
      last_g[i]   = eg;
      l_we[i]     = dwe[i][eg];
      l_addr[i]   = da[i][eg];
      l_wdata[i]  = dd[i][eg];
      l_wstrb[i]  = ds[i][eg];
      en_cyc[i]   = cyc + 1;
      rsp_cyc[i]  = cyc + 2 + lat;
      free_at[i]  = cyc + 3 + lat;
      rsp_port[i] = eg;
      rsp_exp[i]  = dwe[i][eg] ? 32'h0 : memfn(da[i][eg]);
      acc_n[i]++;
      if (i == 0) glog0.push_back(eg); else alog1.push_back(cyc);
    end
  endtask

  always @(negedge clk) begin
    mon(0, LAT_A, bus_a.req0_ready, bus_a.req1_ready, bus_a.mem_en, bus_a.mem_we,
        bus_a.mem_addr, bus_a.mem_wdata, bus_a.mem_wstrb,
        bus_a.rsp0_valid, bus_a.rsp1_valid, bus_a.rsp0_rdata, bus_a.rsp1_rdata);
    mon(1, LAT_B, bus_b.req0_ready, bus_b.req1_ready, bus_b.mem_en, bus_b.mem_we,
        bus_b.mem_addr, bus_b.mem_wdata, bus_b.mem_wstrb,
        bus_b.rsp0_valid, bus_b.rsp1_valid, bus_b.rsp0_rdata, bus_b.rsp1_rdata);
  end

  function automatic logic get_ready(input int i, input int p);
    if (i == 0) return (p == 0) ? bus_a.req0_ready : bus_a.req1_ready;
    return (p == 0) ? bus_b.req0_ready : bus_b.req1_ready;
  endfunction

  function automatic logic get_rv(input int i, input int p);
    if (i == 0) return (p == 0) ? bus_a.rsp0_valid : bus_a.rsp1_valid;
    return (p == 0) ? bus_b.rsp0_valid : bus_b.rsp1_valid;
  endfunction

  function automatic logic [31:0] get_rd(input int i, input int p);
    if (i == 0) return (p == 0) ? bus_a.rsp0_rdata : bus_a.rsp1_rdata;
    return (p == 0) ? bus_b.rsp0_rdata : bus_b.rsp1_rdata;
  endfunction

  task automatic issue(input int i, input int p, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] ws, output int acc);
    bit done;
    done = 0;
    acc  = -1;
    dwe[i][p] = we; da[i][p] = a; dd[i][p] = wd; ds[i][p] = ws; dv[i][p] = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (get_ready(i, p)) begin done = 1; acc = cyc; end
    end
    @(posedge clk); #1;
    dv[i][p] = 1'b0;
    chk("issue_accepted", done, 1);
  endtask

  task automatic wait_rsp(input int i, input int p, output int rc, output logic [31:0] rd);
    bit done;
    done = 0;
    rc   = -1;
    rd   = 32'h0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (get_rv(i, p)) begin done = 1; rc = cyc; rd = get_rd(i, p); end
    end
    chk("rsp_seen", done, 1);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int          acc;
    int          rc;
    int          got;
    int          e0;
    logic        r0;
    logic        r1;
    logic        rr [2][2];
    logic [31:0] rd;

    for (int i = 0; i < 2; i++) begin
      for (int p = 0; p < 2; p++) begin
        dv[i][p] = 0; dwe[i][p] = 0; da[i][p] = 0; dd[i][p] = 0; ds[i][p] = 0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // port 0 read at 0x10
    issue(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, acc);
    wait_rsp(0, 0, rc, rd);
    chk("t1_latency", 32'(rc - acc), LAT_A + 2);
    chk("t1_rdata", rd, 32'hDEADBEEF);

    // port 1 write
    e0 = en_n[0];
    issue(0, 1, 1'b1, 32'd100, 32'd25, 4'hF, acc);
    wait_rsp(0, 1, rc, rd);
    chk("t2_rdata", rd, 32'h0);
    chk("t2_en_pulses", 32'(en_n[0] - e0), 1);
    chk("t2_latency", 32'(rc - acc), LAT_A + 2);

    // continuous contention from reset
    pulse_reset();
    glog0.delete();
    for (int p = 0; p < 2; p++) begin
      dwe[0][p] = 0; da[0][p] = $urandom; dv[0][p] = 1'b1;
    end
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      r0 = get_ready(0, 0);
      r1 = get_ready(0, 1);
      chk("t3_single_ready", r0 && r1, 0);
      @(posedge clk); #1;
      if (r0) begin da[0][0] = $urandom; got++; end
      if (r1) begin da[0][1] = $urandom; got++; end
    end
    dv[0][0] = 0; dv[0][1] = 0;
    chk("t3_grants", got, 4);
    for (int k = 0; k < 4; k++)
      chk("t3_order", (glog0.size() > k) ? glog0[k] : 99, k % 2);
    repeat (8) @(posedge clk);
    #1;

    // port 1 back-to-back reads, LATENCY 3
    alog1.delete();
    dwe[1][1] = 0; da[1][1] = $urandom; dv[1][1] = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 4; c++) begin
      @(negedge clk);
      r1 = get_ready(1, 1);
      @(posedge clk); #1;
      if (r1) begin da[1][1] = $urandom; got++; end
    end
    dv[1][1] = 0;
    chk("t4_accepts", got, 4);
    for (int k = 1; k < 4; k++)
      chk("t4_spacing", (alog1.size() > k) ? 32'(alog1[k] - alog1[k-1]) : 0, LAT_B + 3);
    repeat (8) @(posedge clk);
    #1;

    // reset in the middle of WAIT
    issue(0, 0, 1'b0, 32'h44, 32'h0, 4'h0, acc);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t5_async_mem_addr", bus_a.mem_addr, 0);
    chk("t5_async_mem_en", bus_a.mem_en, 0);
    chk("t5_async_rsp0_valid", bus_a.rsp0_valid, 0);
    chk("t5_async_rsp0_rdata", bus_a.rsp0_rdata, 0);
    chk("t5_async_rsp1_rdata", bus_a.rsp1_rdata, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    glog0.delete();
    for (int p = 0; p < 2; p++) begin
      dwe[0][p] = 0; da[0][p] = $urandom; dv[0][p] = 1'b1;
    end
    got = 0;
    for (int c = 0; c < 20 && got < 1; c++) begin
      @(negedge clk);
      if (get_ready(0, 0) || get_ready(0, 1)) got++;
      @(posedge clk); #1;
    end
    dv[0][0] = 0; dv[0][1] = 0;
    chk("t5_first_grant", (glog0.size() > 0) ? glog0[0] : 99, 0);
    repeat (8) @(posedge clk);
    #1;

    // byte write on port 0
    issue(0, 0, 1'b1, 32'h200, 32'hA5A55A5A, 4'h2, acc);
    wait_rsp(0, 0, rc, rd);
    chk("t6_rdata", rd, 32'h0);
    chk("t6_hold_wstrb", bus_a.mem_wstrb, 4'h2);
    chk("t6_hold_addr", bus_a.mem_addr, 32'h200);
    chk("t6_hold_wdata", bus_a.mem_wdata, 32'hA5A55A5A);
    chk("t6_idle_mem_en", bus_a.mem_en, 0);

    // random traffic on both instances and ports
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++)
        for (int p = 0; p < 2; p++) rr[i][p] = get_ready(i, p);
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        for (int p = 0; p < 2; p++) begin
          if (dv[i][p] && rr[i][p]) dv[i][p] = 0;
          if (!dv[i][p] && $urandom_range(0, 3) == 0) begin
            dwe[i][p] = 1'($urandom_range(0, 1));
            da[i][p]  = $urandom;
            dd[i][p]  = $urandom;
            ds[i][p]  = 4'($urandom_range(0, 15));
            dv[i][p]  = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 2; i++)
      for (int p = 0; p < 2; p++) dv[i][p] = 0;
    repeat (15) @(posedge clk);
    #1;
    chk("rand_a_rsp_count", rsp_n[0], acc_n[0]);
    chk("rand_b_rsp_count", rsp_n[1], acc_n[1]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port, fixed-latency memory between two requesters of the RV32I core: port 0 is instruction fetch, port 1 is data load/store. It accepts one request at a time over a valid/ready handshake and grants round-robin when both ports request together. It drives the memory for one cycle, waits the memory latency, and returns the read data or a write acknowledge on the requester's response channel.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; must be 32
- LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..7

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- reqN_valid  in  1  request present on port N (N = 0, 1)
- reqN_ready  out  1  request accepted this cycle on port N
- reqN_we  in  1  1 = write, 0 = read
- reqN_addr  in  ADDR_W  byte address
- reqN_wdata  in  DATA_W  write data
- reqN_wstrb  in  4  byte enables for writes
- rspN_valid  out  1  one-cycle completion pulse for port N
- rspN_rdata  out  DATA_W  read data; 0 for writes
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_wstrb  out  4  memory byte enables
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after mem_en

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - If exactly one reqN_valid is high, grant that port.
  - If both are high, grant the port not granted last. The last-grant register resets to 1, so port 0 wins first.
  - The granted port sees reqN_ready = 1, computed combinationally and only in IDLE. The handshake completes in that cycle.
  - Latch we, addr, wdata, wstrb, and the port ID. Update last-grant. Go to ISSUE.
- **ISSUE:** mem_en = 1 for exactly one cycle, with the latched fields on mem_*. Load the counter with LATENCY-1. Go to WAIT.
- **WAIT:** Decrement the counter. When the counter equals 0, register mem_rdata into the response register (force 0 if the access was a write). Go to RESP.
- **RESP:**
  - rspN_valid = 1 for the latched port only, for exactly one cycle, with rspN_rdata = the response register.
  - Go to IDLE.
- Ready rules:
  - reqN_ready is never high outside IDLE.
  - req0_ready and req1_ready are never high together.
- A requester holds valid and all fields stable until ready. The arbiter does not buffer a second request.
- When not in ISSUE, mem_en = 0 and mem_we = 0. mem_addr, mem_wdata and mem_wstrb hold their last values.
- rspN_rdata holds its value between pulses. It is only meaningful while rspN_valid = 1.
- Writes always complete through RESP, so every accepted request produces exactly one rspN_valid pulse.
- Counter width is 3 bits, sufficient for LATENCY ≤ 7.

## Timing
- Acceptance at cycle T (valid & ready):
  - mem_en high at T+1.
  - mem_rdata sampled at the edge ending cycle T+1+LATENCY.
  - rspN_valid high at T+2+LATENCY.
- Next possible acceptance is T+3+LATENCY. Throughput is one transaction per LATENCY+3 cycles.
- Reset values (reset = 0, asynchronous):
  - State = IDLE, last-grant = 1, counter = 0.
  - Latched fields and the response register = 0.
  - All outputs are 0.
- Reset mid-transaction: the in-flight access is dropped with no rsp pulse. A mem_en already issued is not recalled.
- After reset deasserts, the first edge with a request present is an IDLE acceptance.
- A request arriving while busy waits. A port's request is never starved: under continuous contention, grants strictly alternate.

## Test plan
- Port 0 read, LATENCY=2, addr 0x10, memory returns 0xDEADBEEF → accept at T, mem_en at T+1, rsp0_valid at T+4 with 0xDEADBEEF, rsp1_valid stays 0.
- Port 1 write, addr 100, wdata 25, wstrb 0xF → mem_en=mem_we=1 once with addr 100, data 25, strb 0xF; rsp1_valid one pulse with rdata 0.
- Both ports valid continuously for 4 transactions from reset → grant order 0,1,0,1; never both ready in one cycle.
- Port 1 only, back-to-back reads with LATENCY=3 → acceptances spaced exactly 6 cycles apart; each rdata matches its address.
- Reset asserted during WAIT → all outputs 0 immediately (asynchronous); no rsp pulse; after release, port 0 wins a simultaneous request.
- Byte write, wstrb 0x2 on port 0 → mem_wstrb = 0x2 during the single mem_en cycle; other mem_* outputs are stable afterward with mem_en = 0.
